pc_sequencer: RTL

Program-counter sequencer for the fetch stage of the MIPS CPU. It owns the PC register and the +4 increment path. It selects the next PC from sequential, branch, jump and jump-register sources, and runs the fetch handshake with instruction memory. It sits between the hazard/control units and the instruction memory port, and is the single writer of `pc`.

---
 rtl/pc_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the MIPS fetch stage.
// It owns the PC register and the +4 path, selects the next PC from the
// sequential, branch, jump and jump-register sources, and runs the fetch
// handshake with instruction memory. It is the only writer of pc.
//
// Optional feature: define PC_ALIGN_CHECK_EN to force redirect targets onto
// a word boundary and to pulse misalign when a misaligned target is used.
// When the macro is undefined, targets load unmodified and misalign is 0.
//
// Ports:
//   clk          system clock, rising edge
//   clrn         asynchronous active-low reset
//   stall        hazard stall, blocks PC advance
//   pcsrc[1:0]   next-PC select: 00 pc+4, 01 bpc, 10 jpc, 11 rpc
//   bpc/jpc/rpc  redirect targets
//   imem_ready   instruction memory returns data this cycle
//   imem_req     fetch request for address pc (decoded from state)
//   pc           current fetch address (registered)
//   pc4          pc + 4, forced to 0 while clrn is low
//   fetch_valid  fetched instruction consumed this cycle
//   state        FSM state for debug (00 BOOT, 01 FETCH, 10 WAIT, 11 HOLD)
//   misalign     pulse in the cycle a misaligned target is used to advance
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] rpc,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        fetch_valid,
    output logic [1:0]  state,
    output logic        misalign
);

    localparam int unsigned AW = 32;
    localparam int unsigned SW = 2;

    typedef enum logic [SW-1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        WAIT  = 2'b10,
        HOLD  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            pend_vld_q, pend_vld_d;
    logic [AW-1:0]   pend_pc_q, pend_pc_d;

    logic [AW-1:0]   pc_inc;
    logic [AW-1:0]   live_tgt;
    logic [AW-1:0]   sel_tgt;
    logic [AW-1:0]   load_tgt;
    logic [AW-1:0]   next_pc;
    logic            redirect;
    logic            use_tgt;
    logic            accept;
    logic            advance;

    // Sequential increment; wraps modulo 2^32.
    assign pc_inc = pc_q + AW'(4);

    // Live redirect target mux.
    always_comb begin
        live_tgt = '0;
        unique case (pcsrc)
            2'b01:   live_tgt = bpc;
            2'b10:   live_tgt = jpc;
            2'b11:   live_tgt = rpc;
            default: live_tgt = '0;
        endcase
    end

    // A live redirect this cycle is newer than any pending one, so it wins.
    assign redirect = (pcsrc != 2'b00);
    assign use_tgt  = redirect | pend_vld_q;
    assign sel_tgt  = redirect ? live_tgt : pend_pc_q;

    // Handshake: request is Moore, consumption is combinational.
    assign imem_req    = (state_q == FETCH) || (state_q == WAIT);
    assign accept      = imem_req & imem_ready;
    assign advance     = accept & ~stall;
    assign fetch_valid = advance;

`ifdef PC_ALIGN_CHECK_EN
    // Word-align the loaded target; flag only when the target is consumed.
    assign load_tgt = {sel_tgt[AW-1:2], 2'b00};
    assign misalign = advance & use_tgt & (sel_tgt[1:0] != 2'b00);
`else
    assign load_tgt = sel_tgt;
    assign misalign = 1'b0;
`endif

    assign next_pc = use_tgt ? load_tgt : pc_inc;

    // State, PC and pending-redirect registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    // Next-state, PC load and redirect capture.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH, WAIT: begin
                if (advance) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end else if (accept) begin
                    state_d = HOLD;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                // Address is refetched unchanged once the stall drops.
                if (!stall) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Redirects seen without an advance are remembered until the next one.
        if (advance) begin
            pend_vld_d = 1'b0;
        end else if (redirect) begin
            pend_vld_d = 1'b1;
            pend_pc_d  = live_tgt;
        end
    end

    assign pc    = pc_q;
    assign state = state_q;
    assign pc4   = clrn ? pc_inc : '0;

endmodule
